// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RAM_RD,
        RAM_WR,
        LD_CAP,
        RSP
    } lsu_state_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane merge for sub-word stores and lane extract/extend for loads.
import lsu_pkg::*;

module lsu_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  mem_size_e             size,
    input  logic [1:0]            off,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] merged,
    output logic [DATA_WIDTH-1:0] extracted
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = old_word[{off, 3'b000} +: 8];
        half_lane = old_word[{off[1], 4'b0000} +: 16];
        merged    = old_word;
        extracted = '0;
        case (size)
            SZ_BYTE: begin
                merged[{off, 3'b000} +: 8] = wdata[7:0];
                extracted = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, byte_lane}
                                        : {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
                extracted = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, half_lane}
                                        : {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            end
            SZ_WORD: begin
                merged    = wdata;
                extracted = old_word;
            end
            default: begin
                merged    = old_word;
                extracted = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a single-port, 1-cycle-read data RAM without byte enables.
import lsu_pkg::*;

module lsu_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [31:0]           i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wrdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    lsu_state_e            state, state_next;
    logic                  accept;
    logic                  req_err;
    mem_size_e             in_size;
    logic                  cap_we;
    mem_size_e             cap_size;
    logic [1:0]            cap_off;
    logic                  cap_uns;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] extracted;
    logic                  unused_addr_hi;

    // Upper byte-address bits alias onto the RAM and are deliberately dropped.
    assign unused_addr_hi = ^i_req_addr[31:ADDR_WIDTH+2];

    assign in_size     = mem_size_e'(i_req_size);
    assign req_err     = is_misaligned(in_size, i_req_addr[1:0]);
    assign o_req_ready = (state == IDLE);
    assign accept      = i_req_valid && o_req_ready;
    assign o_rsp_valid = (state == RSP);
    assign o_ram_we    = (state == RAM_WR);

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .old_word    (i_ram_rdata),
        .wdata       (cap_wdata),
        .size        (cap_size),
        .off         (cap_off),
        .is_unsigned (cap_uns),
        .merged      (merged),
        .extracted   (extracted)
    );

    // Word stores ignore old_word inside the merge, so one path serves all sizes.
    assign o_ram_wrdata = merged;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RSP;
                    else if (i_req_we && in_size == SZ_WORD)
                        state_next = RAM_WR;
                    else
                        state_next = RAM_RD;
                end
            end
            RAM_RD:  state_next = cap_we ? RAM_WR : LD_CAP;
            RAM_WR:  state_next = RSP;
            LD_CAP:  state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_ram_addr  <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            cap_we      <= 1'b0;
            cap_size    <= SZ_BYTE;
            cap_off     <= '0;
            cap_uns     <= 1'b0;
            cap_wdata   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                o_ram_addr <= i_req_addr[ADDR_WIDTH+1:2];
                cap_we     <= i_req_we;
                cap_size   <= in_size;
                cap_off    <= i_req_addr[1:0];
                cap_uns    <= i_req_unsigned;
                cap_wdata  <= i_req_wdata;
            end
            // Only IDLE reaches RSP directly, and only for rejected requests.
            if (state != RSP && state_next == RSP) begin
                o_rsp_err   <= (state == IDLE);
                o_rsp_rdata <= (state == LD_CAP) ? extracted : '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-level transaction model and a per-cycle checker.
module tb_lsu_mem_ctrl;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_uns;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wrdata, ram_rdata;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_addr     (req_addr),
        .i_req_size     (req_size),
        .i_req_unsigned (req_uns),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_ram_we       (ram_we),
        .o_ram_addr     (ram_addr),
        .o_ram_wrdata   (ram_wrdata),
        .i_ram_rdata    (ram_rdata)
    );

    // Behavioural single-port RAM, 1-cycle synchronous read.
    logic [31:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wrdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          rsp_cyc;
        int          we_cyc;
        logic [31:0] rdata;
        logic        err;
        logic        st;
        int          wb;
        logic [31:0] new_word;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  refb [0:16383];
    int          busy_until = -1;
    logic [AW-1:0] exp_ram_addr = '0;
    logic [31:0] held_rdata = '0;
    logic        held_err = 1'b0;
    int          last_acc = 0;
    int          last_rsp_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        exp_v, exp_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle checker against the transaction model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_v  = (q.size() > 0) && (q[0].rsp_cyc == cyc);
                exp_we = (q.size() > 0) && (q[0].we_cyc == cyc);
                chk("rsp_valid", rsp_valid, exp_v);
                chk("req_ready", req_ready, cyc > busy_until);
                chk("ram_we", ram_we, exp_we);
                chk("ram_addr", ram_addr, exp_ram_addr);
                if (exp_we) chk("ram_wrdata", ram_wrdata, q[0].new_word);
                if (exp_v) begin
                    chk("rsp_rdata", rsp_rdata, q[0].rdata);
                    chk("rsp_err", rsp_err, q[0].err);
                    held_rdata   = q[0].rdata;
                    held_err     = q[0].err;
                    last_rsp_cyc = cyc;
                    if (q[0].st)
                        for (int i = 0; i < 4; i++) refb[q[0].wb + i] = q[0].new_word[8*i +: 8];
                    void'(q.pop_front());
                end else begin
                    chk("rsp_rdata_hold", rsp_rdata, held_rdata);
                    chk("rsp_err_hold", rsp_err, held_err);
                end
            end
        end
    end

    // Drive a request at a negedge, wait for acceptance, record the model's expectation.
    task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input bit keep);
        int          n;
        int          wb;
        int          ba;
        exp_t        e;
        logic [7:0]  w [4];
        logic [7:0]  b;
        logic [15:0] h;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = sz;
        req_uns   = uns;
        req_wdata = wd;
        n = 0;
        while (!req_ready) begin
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: ready stayed low for %0d cycles, required high", n);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        ba = int'(addr[13:0]);
        wb = int'({addr[13:2], 2'b00});
        for (int i = 0; i < 4; i++) w[i] = refb[wb + i];
        e.err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        e.st = 1'b0;
        e.wb = wb;
        e.we_cyc = -1;
        e.rdata = '0;
        e.new_word = '0;
        if (e.err) begin
            e.rsp_cyc = cyc;
        end else if (we) begin
            e.st = 1'b1;
            if (sz == 2'b00) begin
                w[addr[1:0]] = wd[7:0];
            end else if (sz == 2'b01) begin
                w[addr[1:0]]     = wd[7:0];
                w[addr[1:0] + 1] = wd[15:8];
            end else begin
                for (int i = 0; i < 4; i++) w[i] = wd[8*i +: 8];
            end
            e.new_word = {w[3], w[2], w[1], w[0]};
            e.we_cyc   = (sz == 2'b10) ? cyc : cyc + 1;
            e.rsp_cyc  = e.we_cyc + 1;
        end else begin
            e.rsp_cyc = cyc + 2;
            if (sz == 2'b00) begin
                b = refb[ba];
                e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end else if (sz == 2'b01) begin
                h = {refb[ba + 1], refb[ba]};
                e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end else begin
                e.rdata = {w[3], w[2], w[1], w[0]};
            end
        end
        q.push_back(e);
        busy_until   = e.rsp_cyc;
        exp_ram_addr = addr[13:2];
        @(negedge clk);
        if (!keep) begin
            req_valid = 1'b0;
            req_addr  = ~addr;
            req_wdata = ~wd;
            req_we    = ~we;
            req_uns   = ~uns;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() > 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", q.size());
            q.delete();
            busy_until = -1;
        end
    endtask

    task automatic run(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
        req(we, addr, sz, uns, wd, 1'b0);
        wait_done();
    endtask

    int acc1;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        for (int i = 0; i < 16384; i++) refb[i] = '0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_uns = 1'b0; req_wdata = '0;
        #1;
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_ram_we", ram_we, 1'b0);
        chk("reset_ram_addr", ram_addr, '0);
        chk("reset_rsp_rdata", rsp_rdata, '0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: word store then word load
        run(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        chk("sw_latency", last_rsp_cyc - last_acc, 1);
        run(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("lw_err", rsp_err, 1'b0);
        chk("lw_latency", last_rsp_cyc - last_acc, 2);

        // 2: byte store read-modify-write
        run(1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344);
        run(1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFF_FFAA);
        chk("sb_latency", last_rsp_cyc - last_acc, 2);
        run(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        chk("sb_lw", rsp_rdata, 32'h1122AA44);
        run(1'b0, 32'h11, 2'b00, 1'b0, 32'h0);
        chk("lb", rsp_rdata, 32'hFFFFFFAA);
        run(1'b0, 32'h11, 2'b00, 1'b1, 32'h0);
        chk("lbu", rsp_rdata, 32'h000000AA);

        // 3: half store read-modify-write
        run(1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344);
        run(1'b1, 32'h12, 2'b01, 1'b0, 32'h0000_8001);
        run(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        chk("sh_lw", rsp_rdata, 32'h80013344);
        run(1'b0, 32'h12, 2'b01, 1'b0, 32'h0);
        chk("lh", rsp_rdata, 32'hFFFF8001);
        run(1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
        chk("lhu", rsp_rdata, 32'h00008001);

        // 4: rejected requests
        run(1'b0, 32'h13, 2'b10, 1'b0, 32'h0);
        chk("err_lw_err", rsp_err, 1'b1);
        chk("err_lw_latency", last_rsp_cyc - last_acc, 0);
        run(1'b1, 32'h11, 2'b01, 1'b0, 32'hCAFE);
        chk("err_sh_err", rsp_err, 1'b1);
        chk("err_sh_rdata", rsp_rdata, 32'h0);
        run(1'b1, 32'h10, 2'b11, 1'b0, 32'h12345678);
        chk("err_sz_err", rsp_err, 1'b1);
        run(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        chk("err_unchanged", rsp_rdata, 32'h80013344);

        // 5: reset during RAM_RD of a byte store
        req(1'b1, 32'h10, 2'b00, 1'b0, 32'h55, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ram_we", ram_we, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_ready", req_ready, 1'b1);
        q.delete();
        busy_until   = -1;
        exp_ram_addr = '0;
        held_rdata   = '0;
        held_err     = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        chk("midrst_prior_word", rsp_rdata, 32'h80013344);

        // 6: valid held high across back-to-back requests; upper address bits alias
        req(1'b1, 32'h4010, 2'b10, 1'b0, 32'h1, 1'b1);
        acc1 = last_acc;
        req(0, 32'h0010, 2'b10, 1'b0, 32'h0, 1'b0);
        chk("b2b_accept_gap", last_acc - acc1, 3);
        wait_done();
        chk("alias_lw", rsp_rdata, 32'h00000001);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller between the core's memory stage and the single-port data RAM `ram`. The RAM has a 1-cycle synchronous read and no byte enables.
Accepts byte/half/word loads and stores at byte addresses. Does lane alignment and sign/zero extension for loads. Sub-word stores use read-modify-write.
Handles one transaction at a time, with a valid/ready request and a single-cycle response pulse.

Parameters:
DATA_WIDTH, 32, RAM word width; only 32 supported.
ADDR_WIDTH, 12, RAM word-address width; byte-address bits [ADDR_WIDTH+1:2] select the word.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  controller can accept; high only in IDLE
i_req_we  in  1  1=store, 0=load
i_req_addr  in  32  byte address
i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_req_unsigned  in  1  zero-extend load (LBU/LHU)
i_req_wdata  in  32  store data, right-justified
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_rdata  out  32  extended load data; 0 for stores/errors
o_rsp_err  out  1  misaligned/illegal-size request
o_ram_we  out  1  to ram i_we
o_ram_addr  out  ADDR_WIDTH  to ram i_addr
o_ram_wrdata  out  32  to ram i_wrdata
i_ram_rdata  in  32  from ram o_rdata

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, o_ram_we=0, o_ram_addr=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - o_ram_we deasserts immediately, not at the next edge.
- Accept:
  - A request is accepted on the edge where i_req_valid && o_req_ready.
  - All request fields are captured at that edge; later changes are ignored.
- States: IDLE, RAM_RD, RAM_WR, LD_CAP, RSP.
- Transitions from IDLE on accept:
  - Error → RSP.
  - Word store → RAM_WR.
  - Any load or sub-word store → RAM_RD.
- Transitions from the other states:
  - RAM_RD → LD_CAP (load) or RAM_WR (sub-word store).
  - RAM_WR → RSP.
  - LD_CAP → RSP.
  - RSP → IDLE.
- Error conditions:
  - size=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
  - On error, no RAM access occurs (o_ram_we never 1); RSP carries err=1, rdata=0.
- RAM-side outputs:
  - o_ram_addr = captured addr[ADDR_WIDTH+1:2], held from the accept edge until the next accept.
  - Byte-address bits above ADDR_WIDTH+1 are ignored, so addresses alias/wrap.
  - o_ram_we=1 only in RAM_WR.
- Store data:
  - Word: wrdata = captured wdata.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lane addr[1].
  - Other lanes come from i_ram_rdata, sampled in RAM_WR (valid because RAM_RD presented the same address).
- Load:
  - In LD_CAP, the lane of i_ram_rdata is selected and sign-extended (or zero-extended if unsigned).
  - The result is registered into o_rsp_rdata at the LD_CAP→RSP edge.
- Latency, with N = accept edge; o_rsp_valid is high for exactly the cycle after the listed edge:
  - Error: after N.
  - Word store: RAM write at N+1; response after N+1.
  - Sub-word store: RAM write at N+2; response after N+2.
  - Load: response after N+2.
- Next accept: earliest is the RSP→IDLE edge + 1 cycle.
- Response handshake: no backpressure; the requester must take the response in the pulse cycle.
- o_rsp_err and o_rsp_rdata are valid only while o_rsp_valid=1; they hold until the next response.
- Reset mid-operation:
  - The transaction is abandoned with no response.
  - If reset hits before the RAM_WR edge, the RAM is unmodified.

Decomposition:
- Package lsu_pkg holds:
  - enum mem_size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL};
  - enum lsu_state_e;
  - function is_misaligned().
- One combinational sub-module lsu_align holds:
  - store merge: old word, wdata, size, addr[1:0] → new word;
  - load extract: word, size, addr[1:0], unsigned → result.
- The FSM and registers live in lsu_mem_ctrl.

Test Plan:
All scenarios use lsu_mem_ctrl connected to `ram` with ADDR_WIDTH=12.
1. SW 0xDEADBEEF@0x10, then LW@0x10 → rdata=0xDEADBEEF, err=0; store rsp 1 edge after the write, load rsp exactly N+2.
2. SW 0x11223344@0x10; SB 0xAA@0x11 → LW@0x10=0x1122AA44; LB@0x11=0xFFFFFFAA; LBU@0x11=0x000000AA.
3. SW 0x11223344@0x10; SH 0x8001@0x12 → LW=0x80013344; LH@0x12=0xFFFF8001; LHU=0x00008001.
4. LW@0x13, SH@0x11, size=11@0x10 → each: rsp one cycle after accept, err=1, rdata=0, o_ram_we stays 0, 0x10 contents unchanged.
5. Assert i_rst_n=0 during RAM_RD of SB 0x55@0x10 → o_rsp_valid never pulses, ready=1 after release, LW@0x10 returns the prior word.
6. i_req_valid held high with back-to-back SW 1@0x4010 then LW@0x0010 → second accepted only in IDLE, ready low in between, load returns 0x00000001 (alias).
